// File: rtl/i2c_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_arbiter_pkg
//  Brief    : Shared state encoding, command width and defaults for the
//             I2C command arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_cmd_arbiter_pkg;

    localparam int CMD_W           = 24;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_TIMEOUT_CYC = 2000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_arbiter_if
//  Brief    : Requester and I2C-engine handshake bundle of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_cmd_arbiter_if #(
    parameter int NUM_REQ = 3
) ();
    import i2c_cmd_arbiter_pkg::*;

    logic [NUM_REQ-1:0]       iREQ;
    logic [CMD_W*NUM_REQ-1:0] iREQ_DATA;
    logic [NUM_REQ-1:0]       oDONE;
    logic [NUM_REQ-1:0]       oERR;
    logic                     oBUSY;
    logic                     oXFER_GO;
    logic [CMD_W-1:0]         oXFER_DATA;
    logic                     iXFER_END;
    logic                     iXFER_NACK;

    // Requesters and engine side
    modport master (
        output iREQ, iREQ_DATA, iXFER_END, iXFER_NACK,
        input  oDONE, oERR, oBUSY, oXFER_GO, oXFER_DATA
    );

    // Arbiter side
    modport slave (
        input  iREQ, iREQ_DATA, iXFER_END, iXFER_NACK,
        output oDONE, oERR, oBUSY, oXFER_GO, oXFER_DATA
    );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin grant, searching from last_grant+1.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   last_grant,
    output logic                    grant_valid,
    output logic [IDX_W-1:0]        grant_idx
);

    int cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_valid && (|(req & (NUM_REQ'(1) << cand)))) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_arbiter
//  Brief    : Round-robin arbiter sharing one I2C engine between requesters,
//             with NACK retry and per-attempt timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire logic         iCLK,
    input  wire logic         iRST_N,
    i2c_cmd_arbiter_if.slave  bus
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int RT_W  = clog2_min1(MAX_RETRY + 1);
    localparam int TO_W  = clog2_min1(TIMEOUT_CYC + 1);

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_grant;
    logic [RT_W-1:0]    retry_cnt;
    logic [TO_W-1:0]    tmo_cnt;
    logic               nack_seen;
    logic               xfer_go;
    logic [CMD_W-1:0]   xfer_data;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic               busy;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] owner_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (bus.iREQ),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign owner_oh = NUM_REQ'(1) << owner;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            nack_seen  <= 1'b0;
            xfer_go    <= 1'b0;
            xfer_data  <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        xfer_data <= CMD_W'(bus.iREQ_DATA >> (CMD_W * int'(grant_idx)));
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        xfer_go   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.iXFER_END) begin
                        nack_seen <= bus.iXFER_NACK;
                        xfer_go   <= 1'b0;
                        state     <= ST_RELEASE;
                    end else if (tmo_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        // An attempt that never ends is treated like a NACK.
                        nack_seen <= 1'b1;
                        xfer_go   <= 1'b0;
                        state     <= ST_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.iXFER_END) state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (nack_seen && (retry_cnt < RT_W'(MAX_RETRY))) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        tmo_cnt   <= '0;
                        xfer_go   <= 1'b1;
                        state     <= ST_ISSUE;
                    end else begin
                        done  <= owner_oh;
                        err   <= nack_seen ? owner_oh : '0;
                        state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    xfer_go <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oXFER_GO   = xfer_go;
    assign bus.oXFER_DATA = xfer_data;
    assign bus.oDONE      = done;
    assign bus.oERR       = err;
    assign bus.oBUSY      = busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_cmd_arbiter
//  Brief    : Self-checking bench: vector table, corner sequences and random
//             rounds against a round-robin/retry reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_arbiter;

    localparam int NREQ  = 3;
    localparam int MRTRY = 3;
    localparam int TMO   = 100;

    typedef struct {
        logic [2:0] req;
        logic [3:0] nack;
        bit         tmo;
        int         owner;
        int         gos;
        bit         err;
    } vec_t;

    typedef struct { int lat; bit nack; bit tmo; } resp_t;

    typedef struct {
        logic [2:0]  done;
        logic [2:0]  err;
        int          gos;
        logic [23:0] data;
        int          max_run;
    } drec_t;

    typedef struct { int owner; logic [23:0] data; bit err; int gos; bit tmo; } exp_t;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    resp_t resp_q[$];
    drec_t done_q[$];
    logic [23:0] slot[3];

    i2c_cmd_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    i2c_cmd_arbiter #(
        .NUM_REQ     (NREQ),
        .MAX_RETRY   (MRTRY),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, records each completed command.
    logic        go_prev   = 1'b0;
    logic [23:0] data_prev = '0;
    logic [23:0] go_data   = '0;
    int          go_cnt = 0, run = 0, max_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            go_cnt = 0; run = 0; max_run = 0;
        end else begin
            if (bus.oXFER_DATA !== data_prev)
                chk("data_changes_only_on_grant", 32'(bus.oXFER_GO && !go_prev), 32'd1);
            if (bus.oXFER_GO && !go_prev) begin
                chk("go_rise_with_end_low", 32'(bus.iXFER_END), 32'd0);
                go_cnt++;
                go_data = bus.oXFER_DATA;
                run = 0;
            end
            if (bus.oXFER_GO) begin
                run++;
                if (run > max_run) max_run = run;
            end
            if (bus.oDONE != '0) begin
                done_q.push_back('{bus.oDONE, bus.oERR, go_cnt, go_data, max_run});
                go_cnt = 0; max_run = 0;
            end
        end
        go_prev   = bus.oXFER_GO;
        data_prev = bus.oXFER_DATA;
    end

    // Engine model: one response per GO pulse, 4-phase END handshake.
    initial begin
        resp_t r;
        bus.iXFER_END  = 1'b0;
        bus.iXFER_NACK = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst_n && bus.oXFER_GO && !bus.iXFER_END) begin
                r = (resp_q.size() != 0) ? resp_q.pop_front() : '{2, 1'b0, 1'b0};
                for (int k = 0; k < r.lat && bus.oXFER_GO; k++) begin @(negedge clk); #1; end
                if (bus.oXFER_GO && !r.tmo) begin
                    bus.iXFER_END  = 1'b1;
                    bus.iXFER_NACK = r.nack;
                end
                for (int k = 0; k < 1000 && bus.oXFER_GO; k++) begin @(negedge clk); #1; end
                repeat ($urandom_range(1, 2)) @(negedge clk);
                #1;
                bus.iXFER_END  = 1'b0;
                bus.iXFER_NACK = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic apply_data();
        bus.iREQ_DATA = {slot[2], slot[1], slot[0]};
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        bus.iREQ = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        resp_q.delete();
        done_q.delete();
    endtask

    // Waits for the next completion; optionally scrambles the owner's data
    // while it holds the engine (that change must not reach the engine).
    task automatic wait_done(input int scr_owner, output drec_t d);
        d = '{3'b0, 3'b0, 0, 24'h0, 0};
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #2;
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                return;
            end
            if (scr_owner >= 0 && bus.oBUSY && $urandom_range(0, 3) == 0) begin
                slot[scr_owner] = 24'($urandom);
                apply_data();
            end
        end
        vectors++; miscompares++;
        $display("FAIL done_wait: got no oDONE, expected one within 3000 cycles");
    endtask

    task automatic check_txn(input string tag, input drec_t d, input exp_t e);
        chk({tag, "_done"}, 32'(d.done), 32'(3'b001 << e.owner));
        chk({tag, "_err"},  32'(d.err),  e.err ? 32'(3'b001 << e.owner) : 32'd0);
        chk({tag, "_gos"},  32'(d.gos),  32'(e.gos));
        chk({tag, "_data"}, 32'(d.data), 32'(e.data));
        if (e.tmo) chk({tag, "_go_width"}, 32'(d.max_run), 32'(TMO));
    endtask

    vec_t  tbl[9];
    drec_t d;
    exp_t  ex;
    exp_t  exp_q[$];
    int    m_last;

    initial begin
        tbl[0] = '{3'b001, 4'b0000, 1'b0, 0, 1, 1'b0};
        tbl[1] = '{3'b011, 4'b0011, 1'b0, 1, 3, 1'b0};
        tbl[2] = '{3'b111, 4'b1111, 1'b0, 2, 4, 1'b1};
        tbl[3] = '{3'b110, 4'b0001, 1'b0, 1, 2, 1'b0};
        tbl[4] = '{3'b101, 4'b0000, 1'b0, 2, 1, 1'b0};
        tbl[5] = '{3'b100, 4'b0000, 1'b0, 2, 1, 1'b0};
        tbl[6] = '{3'b011, 4'b0111, 1'b0, 0, 4, 1'b0};
        tbl[7] = '{3'b001, 4'b1111, 1'b1, 0, 4, 1'b1};
        tbl[8] = '{3'b010, 4'b1000, 1'b0, 1, 1, 1'b0};

        rst_n = 1'b0;
        bus.iREQ = '0;
        for (int k = 0; k < 3; k++) slot[k] = '0;
        apply_data();
        repeat (2) @(negedge clk);
        chk("rst_go",   32'(bus.oXFER_GO),   32'd0);
        chk("rst_data", 32'(bus.oXFER_DATA), 32'd0);
        chk("rst_done", 32'(bus.oDONE),      32'd0);
        chk("rst_err",  32'(bus.oERR),       32'd0);
        chk("rst_busy", 32'(bus.oBUSY),      32'd0);
        do_reset();

        // Contention from reset: 0,1,2 then 0 again while it keeps requesting.
        slot[0] = 24'h111111; slot[1] = 24'h222222; slot[2] = 24'h333333;
        apply_data();
        bus.iREQ = 3'b111;
        wait_done(-1, d); check_txn("cont0", d, '{0, 24'h111111, 1'b0, 1, 1'b0});
        wait_done(-1, d); bus.iREQ = 3'b101;
        check_txn("cont1", d, '{1, 24'h222222, 1'b0, 1, 1'b0});
        wait_done(-1, d); bus.iREQ = 3'b001;
        check_txn("cont2", d, '{2, 24'h333333, 1'b0, 1, 1'b0});
        wait_done(-1, d); bus.iREQ = 3'b000;
        check_txn("cont3", d, '{0, 24'h111111, 1'b0, 1, 1'b0});
        repeat (10) @(negedge clk);
        chk("cont_no_extra_done", 32'(done_q.size()), 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int a = 0; a < 4; a++)
                resp_q.push_back('{(i == 0) ? 10 : $urandom_range(1, 6),
                                   tbl[i].nack[a], tbl[i].tmo});
            for (int k = 0; k < 3; k++) slot[k] = 24'($urandom);
            if (i == 0) slot[0] = 24'h34001A;
            apply_data();
            ex = '{tbl[i].owner, slot[tbl[i].owner], tbl[i].err, tbl[i].gos, tbl[i].tmo};
            bus.iREQ = tbl[i].req;
            wait_done(-1, d);
            bus.iREQ = '0;
            check_txn($sformatf("vec%0d", i), d, ex);
            resp_q.delete();
            repeat (4) @(negedge clk);
        end

        // Reset while ISSUE is active: GO drops at once, no completion.
        resp_q.push_back('{0, 1'b1, 1'b1});
        bus.iREQ = 3'b010;
        for (int n = 0; n < 100 && !bus.oXFER_GO; n++) @(negedge clk);
        chk("rst_mid_go_seen", 32'(bus.oXFER_GO), 32'd1);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        bus.iREQ = '0;
        #1;
        chk("rst_mid_go",   32'(bus.oXFER_GO), 32'd0);
        chk("rst_mid_busy", 32'(bus.oBUSY),    32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_q.size()), 32'd0);
        resp_q.delete();
        slot[0] = 24'hA5A5A5; slot[1] = 24'h5A5A5A;
        apply_data();
        bus.iREQ = 3'b011;
        wait_done(-1, d);
        bus.iREQ = '0;
        check_txn("rst_restart", d, '{0, 24'hA5A5A5, 1'b0, 1, 1'b0});

        // Random rounds against the reference model.
        do_reset();
        m_last = NREQ - 1;
        for (int rnd = 0; rnd < 25; rnd++) begin
            logic [2:0] mask, pend;
            int c, att;
            bit fail;
            mask = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) slot[k] = 24'($urandom);
            apply_data();
            pend = mask;
            while (pend != 0) begin
                c = -1;
                for (int s = 1; s <= NREQ && c < 0; s++)
                    if (pend[(m_last + s) % NREQ]) c = (m_last + s) % NREQ;
                pend[c] = 1'b0;
                m_last  = c;
                att = 0;
                fail = 1'b1;
                while (fail && att <= MRTRY) begin
                    resp_t r;
                    r.lat  = $urandom_range(1, 8);
                    r.tmo  = ($urandom_range(0, 39) == 0);
                    r.nack = ($urandom_range(0, 2) == 0);
                    resp_q.push_back(r);
                    fail = r.tmo || r.nack;
                    att++;
                end
                exp_q.push_back('{c, slot[c], fail, att, 1'b0});
            end
            bus.iREQ = mask;
            while (exp_q.size() != 0) begin
                ex = exp_q.pop_front();
                wait_done(ex.owner, d);
                bus.iREQ[ex.owner] = 1'b0;
                check_txn($sformatf("rnd%0d", rnd), d, ex);
            end
            repeat (4) @(negedge clk);
            chk("rnd_attempts_used", 32'(resp_q.size()), 32'd0);
            resp_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
